branch_history_table: RTL

Bimodal direction predictor plus resolution stage for RISC-V conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU). It predicts taken or not-taken at fetch from a table of 2-bit saturating counters indexed by PC. At execute it consumes the actual outcome produced by the branch comparator. From that outcome it updates the table, flags mispredictions with a registered redirect, and keeps performance counters.

---
 rtl/branch_history_table.sv | 92 +++++++++
 1 files changed

// File: rtl/branch_history_table.sv
// Bimodal branch direction predictor with execute-stage resolution:
// 2-bit saturating counters indexed by PC, a registered mispredict/redirect
// output, and saturating performance counters.
module branch_history_table #(
    parameter int unsigned INDEX_BITS = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic        res_pred_taken,
    input  logic [31:0] res_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]            bht_q [ENTRIES];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] res_idx;
    logic [1:0]            cur_cnt;
    logic [1:0]            next_cnt;
    logic                  miss;
    logic [31:0]           fix_pc;
    logic                  unused_pc_bits;

    assign pred_idx = pred_pc[INDEX_BITS+1:2];
    assign res_idx  = res_pc[INDEX_BITS+1:2];

    // Byte offset and bits above the index never affect the prediction.
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};

    // Prediction reads the stored counter directly; no bypass from the update.
    assign pred_taken = bht_q[pred_idx][1];

    // Saturating counter step, misprediction detect and corrected next PC.
    always_comb begin
        cur_cnt  = bht_q[res_idx];
        next_cnt = cur_cnt;
        if (res_taken) begin
            if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'd1;
        end else begin
            if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'd1;
        end
        miss   = res_valid & (res_taken != res_pred_taken);
        fix_pc = res_taken ? res_target : res_pc + 32'd4;
    end

    // Counter table training on resolved branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                bht_q[i] <= INIT_STATE;
            end
        end else if (res_valid) begin
            bht_q[res_idx] <= next_cnt;
        end
    end

    // Registered mispredict pulse and redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            mispredict <= miss;
            if (miss) redirect_pc <= fix_pc;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            if (res_valid && branch_count != CNT_MAX)
                branch_count <= branch_count + 32'd1;
            if (miss && mispredict_count != CNT_MAX)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule
